// File: rtl/tick_pkg.sv
// Shared constants for the tick enable generator: mode encodings and default sizing.
package tick_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int unsigned TICK_CHANNELS       = 2;
    localparam int unsigned TICK_WIDTH          = 27;
    localparam int unsigned TICK_CNT_W          = 16;
    localparam int unsigned TICK_DEFAULT_PERIOD = 100_000_000;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: programmable period divider with one-shot support and a wrapping tick counter.
module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned          WIDTH          = TICK_WIDTH,
    parameter int unsigned          CNT_W          = TICK_CNT_W,
    parameter logic [WIDTH-1:0]     DEFAULT_PERIOD = WIDTH'(TICK_DEFAULT_PERIOD)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             clear_all,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    output logic             tick,
    output logic             active,
    output logic [CNT_W-1:0] tick_count
);

    logic [WIDTH-1:0] period;
    logic             mode;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             idle;
    logic             terminal;

    // A zero period idles the channel, so the terminal compare never sees P-1 underflow.
    assign idle     = hold || !en || (period == '0);
    assign terminal = (count == period - WIDTH'(1));
    assign active   = en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period     <= DEFAULT_PERIOD;
            mode       <= MODE_PERIODIC;
            en         <= 1'b1;
            count      <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else if (clear_all) begin
            count      <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else if (wr_sel) begin
            period     <= cfg_period;
            mode       <= cfg_mode;
            en         <= cfg_en;
            count      <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else if (idle) begin
            tick       <= 1'b0;
        end else if (terminal) begin
            count      <= '0;
            tick       <= 1'b1;
            tick_count <= tick_count + CNT_W'(1);
            if (mode == MODE_ONESHOT) begin
                en <= 1'b0;
            end
        end else begin
            count      <= count + WIDTH'(1);
            tick       <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_enable_gen.sv
// Multi-channel tick generator: decodes configuration writes and bundles per-channel outputs.
module tick_enable_gen
    import tick_pkg::*;
#(
    parameter int unsigned CHANNELS       = TICK_CHANNELS,
    parameter int unsigned WIDTH          = TICK_WIDTH,
    parameter int unsigned CNT_W          = TICK_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = TICK_DEFAULT_PERIOD
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      clear_all,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_ch,
    input  logic [WIDTH-1:0]          cfg_period,
    input  logic                      cfg_mode,
    input  logic                      cfg_en,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       active,
    output logic [CHANNELS*CNT_W-1:0] tick_count
);

    logic [CHANNELS-1:0] wr_sel;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Channel numbers at or above CHANNELS never match, so such writes fall on the floor.
        assign wr_sel[c] = cfg_we && (cfg_ch == 3'(c));

        tick_channel #(
            .WIDTH          (WIDTH),
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (WIDTH'(DEFAULT_PERIOD))
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .hold       (hold),
            .clear_all  (clear_all),
            .wr_sel     (wr_sel[c]),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .cfg_en     (cfg_en),
            .tick       (tick[c]),
            .active     (active[c]),
            .tick_count (tick_count[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/tick_enable_gen.md
# tick_enable_gen

Parametrised multi-channel tick generator producing single-cycle clock-enable pulses from the 100 MHz system clock. It generalises the fixed one-second divider that slows the CPU and its memories with per-channel runtime-programmable periods, periodic/one-shot modes, global hold and clear, and per-channel tick counters. It sits beside the CPU/VGA wrapper. Its tick outputs drive slowed processor stepping, game-physics updates and scoreboard refresh. Collision hookup: the collision signal goes to `clear_all`, which restarts the counts; `hold` freezes them instead.

## Interface
- `CHANNELS`, 2: number of independent tick channels (1..8).
- `WIDTH`, 27: period/counter width in bits.
- `CNT_W`, 16: per-channel tick-counter width.
- `DEFAULT_PERIOD`, 100_000_000: period loaded into every channel at reset (1 s at 100 MHz).
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `hold`  in  1  global freeze: counts held, ticks forced low.
- `clear_all`  in  1  synchronous clear of all counts, ticks and tick counters; config untouched.
- `cfg_we`  in  1  configuration write strobe, one cycle.
- `cfg_ch`  in  3  target channel; values >= CHANNELS are ignored.
- `cfg_period`  in  WIDTH  new period P.
- `cfg_mode`  in  1  0 = periodic, 1 = one-shot.
- `cfg_en`  in  1  channel enable.
- `tick`  out  CHANNELS  registered single-cycle enable pulse per channel.
- `active`  out  CHANNELS  channel enable state.
- `tick_count`  out  CHANNELS*CNT_W  per-channel wrapping tick counter; channel c occupies bits [c*CNT_W +: CNT_W].

## Operation
- Per-channel state: period, mode, en, count (WIDTH bits), tcnt (CNT_W bits).
- Reset values:
  - period = DEFAULT_PERIOD, mode = periodic, en = 1.
  - count = 0, tcnt = 0.
  - tick = 0, active = all ones.
- Each clock edge, the highest-priority matching rule below applies to each channel:
  1. `clear_all`: count = 0, tick = 0, tcnt = 0.
  2. Config write addressed to this channel:
     - period, mode and en are loaded.
     - count = 0, tick = 0, tcnt = 0.
     - The write wins over a coincident terminal count, so no tick is generated in that case.
  3. `hold`, or en = 0, or period = 0: count unchanged, tick = 0.
  4. count == P-1 (terminal):
     - count = 0, tick = 1, tcnt = tcnt + 1 (wraps modulo 2^CNT_W).
     - In one-shot mode, en is also cleared to 0.
  5. Otherwise: count = count + 1, tick = 0.
- P = 1 gives a tick on every cycle, so tick is continuously high while enabled.
- P = 0 idles the channel; `active` still reflects en.
- Channels are fully independent. A config write to one channel does not disturb the others.
- Arithmetic is unsigned. The count never exceeds P-1. If a new P is written, count restarts from 0, so there is never a stale comparison.

## Timing
- After reset deassertion or a config write with en = 1, the first tick is high during the cycle following the P-th active edge. Subsequent ticks follow every P active cycles.
- Tick high time is exactly one clock cycle, except P = 1.
- `hold` stretches the period by exactly the number of held cycles. The phase is otherwise preserved.
- `clear_all` restarts the phase: the next tick comes P active edges after the clear edge.
- One-shot mode: exactly one tick is produced. `active` drops in the same cycle the tick is high.
- A reset asserted mid-period clears everything immediately, without waiting for a clock edge.

## Structure
- Package `tick_pkg`:
  - Constants MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1.
  - Default WIDTH / DEFAULT_PERIOD values.
- Sub-module `tick_channel`:
  - Holds one channel's registers and the priority logic.
  - Has a per-channel write-select input.
  - Instantiated CHANNELS times with a generate loop.
- Top level:
  - Decodes `cfg_ch` into per-channel write selects.
  - Concatenates the channel outputs.

## Test plan
- Reset with defaults overridden to DEFAULT_PERIOD = 5, CHANNELS = 2 -> both ticks at cycles 5, 10, 15 after reset release; tick_count = 1, 2, 3.
- Write ch1 P = 3, one-shot, en = 1 -> ch1 tick exactly once, 3 cycles later; active[1] falls with the tick; ch0 unaffected.
- Periodic P = 4, hold high for 6 cycles mid-period -> next tick delayed by exactly 6 cycles; no tick while held.
- Periodic P = 4, clear_all asserted at count = 2 -> count and tick_count become 0; next tick 4 cycles after the clear edge.
- Config write landing on the terminal-count cycle -> no tick emitted; new period takes effect from 0.
- P = 1 -> tick continuously high; P = 0 -> no ticks while active = 1; cfg_ch = 5 -> no channel changes; CNT_W = 4 with 16 ticks -> tick_count wraps to 0.
